// File: rtl/display_scan_7seg.sv
// Multiplexed common-anode 7-segment scanner with a blanking gap at the start of every slot.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zeros on digits above digit 0.
module display_scan_7seg #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Digits_in,
    input  logic [DIGITS-1:0]     Dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  Frame,
    output logic                  o_dbg_state
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]   r_dp;
    logic [6:0]          r_seg;
    logic                r_dp_out;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame;

    logic [3:0]          w_digit;
    logic                w_dp_req;
    logic                w_lz_blank;
    logic [DIGITS-1:0]   w_an_show;
    logic [6:0]          w_seg_show;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Load is a bare strobe: no valid/ready pairing, no busy, no ack. When high at a
    // rising edge the whole digit/dp vector is captured at that same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_digits <= '0;
            r_dp     <= '0;
        end else if (Load) begin
            r_digits <= Digits_in;
            r_dp     <= Dp_in;
        end
    end

    always_comb begin
        w_digit  = 4'd0;
        w_dp_req = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit  = r_digits[4*i +: 4];
                w_dp_req = r_dp[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_upper_zero;
    logic              v_zero;

    // Digit i is a leading zero when it and every more significant digit are zero.
    always_comb begin
        w_upper_zero = '0;
        v_zero       = 1'b1;
        w_lz_blank   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            v_zero = 1'b1;
            for (int j = i; j < DIGITS; j++) begin
                if (r_digits[4*j +: 4] != 4'd0) begin
                    v_zero = 1'b0;
                end
            end
            w_upper_zero[i] = v_zero;
        end
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_lz_blank = w_upper_zero[i];
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_an_show  = ~(DIGITS'(1) << r_idx);
    assign w_seg_show = w_lz_blank ? 7'h7F : seg_decode(w_digit);

    // Scan FSM: slot counter, digit index, phase and all display outputs, registered from
    // the pre-edge state so every output lags its controlling state by one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_BLANK;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_frame  <= 1'b0;
            r_seg    <= 7'h7F;
            r_dp_out <= 1'b1;
            r_an     <= '1;
        end else begin
            r_frame <= 1'b0;
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                r_frame <= (r_idx == IDX_LAST);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                ST_BLANK: begin
                    r_seg    <= 7'h7F;
                    r_dp_out <= 1'b1;
                    r_an     <= '1;
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    r_seg    <= w_seg_show;
                    r_dp_out <= ~w_dp_req;
                    r_an     <= w_an_show;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_BLANK;
                    end
                end
                default: begin
                    r_state  <= ST_BLANK;
                    r_seg    <= 7'h7F;
                    r_dp_out <= 1'b1;
                    r_an     <= '1;
                end
            endcase
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp_out;
    assign an          = r_an;
    assign Frame       = r_frame;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Directed + randomized check of display_scan_7seg against a cycle-position reference model.
module tb_display_scan_7seg;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;
    localparam int FRAME_LEN   = DIGITS * REFRESH_DIV;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    logic        CLK;
    logic        RST_N;
    logic        Load;
    logic [15:0] Digits_in;
    logic [3:0]  Dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        Frame;
    logic        o_dbg_state;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          last_frame;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;

    display_scan_7seg #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Load        (Load),
        .Digits_in   (Digits_in),
        .Dp_in       (Dp_in),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .Frame       (Frame),
        .o_dbg_state (o_dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        check({tag, "_an"}, {28'd0, an}, 32'hF);
        check({tag, "_dp"}, {31'd0, dp}, 32'h1);
        check({tag, "_frame"}, {31'd0, Frame}, 32'h0);
    endtask

    // One clock: apply inputs, take the edge, compare outputs with the model position
    // (cyc = clocks since reset release before this edge), then let the capture land.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
        int          pos;
        int          k;
        bit          lit;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [6:0]  e_seg;
        logic [3:0]  e_an;
        logic        e_dp;
        logic        e_frame;
        Load      = ld;
        Digits_in = d;
        Dp_in     = p;
        @(posedge CLK);
        #1;
        pos     = cyc % REFRESH_DIV;
        k       = (cyc / REFRESH_DIV) % DIGITS;
        lit     = (pos >= BLANK_CYC);
        upper   = m_dig >> (4 * k);
        nib     = upper[3:0];
        e_seg   = lit ? SEG_TAB[nib] : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        if (lit && k > 0 && upper == 16'h0) e_seg = 7'h7F;
`endif
        e_an    = lit ? ~(4'b0001 << k) : 4'hF;
        e_dp    = lit ? ~m_dp[k] : 1'b1;
        e_frame = ((cyc % FRAME_LEN) == FRAME_LEN - 1);
        check("seg", {25'd0, seg}, {25'd0, e_seg});
        check("an", {28'd0, an}, {28'd0, e_an});
        check("dp", {31'd0, dp}, {31'd0, e_dp});
        check("frame", {31'd0, Frame}, {31'd0, e_frame});
        if (Frame === 1'b1) begin
            if (last_frame >= 0) check("frame_period", 32'(cyc - last_frame), 32'(FRAME_LEN));
            last_frame = cyc;
        end
        if (ld) begin
            m_dig = d;
            m_dp  = p;
        end
        cyc++;
        Load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, Digits_in, Dp_in);
    endtask

    task automatic model_reset();
        cyc        = 0;
        last_frame = -1;
        m_dig      = 16'h0;
        m_dp       = 4'h0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        RST_N     = 1'b0;
        Load      = 1'b0;
        Digits_in = 16'h0;
        Dp_in     = 4'h0;
        model_reset();

        // Reset held while the clock toggles.
        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("rst_hold");
        @(negedge CLK);
        RST_N = 1'b1;

        // Empty snapshot, first lit cycle, then the 1234 example.
        idle(3);
        step(1'b1, 16'h1234, 4'b0100);
        idle(40);

        // Out-of-range codes show a dash.
        step(1'b1, 16'hFA09, 4'b1001);
        idle(34);

        // All-zero and single leading digit patterns.
        step(1'b1, 16'h0000, 4'b0000);
        idle(33);
        step(1'b1, 16'h0100, 4'b0010);
        idle(33);

        // Capture coinciding with the digit 0 -> 1 slot change.
        while ((cyc % FRAME_LEN) != REFRESH_DIV - 1) idle(1);
        step(1'b1, 16'h5678, 4'b0010);
        idle(12);

        // Capture in the middle of a SHOW phase.
        while ((cyc % REFRESH_DIV) != BLANK_CYC + 2) idle(1);
        step(1'b1, 16'h9087, 4'b1000);
        idle(6);

        // Random captures of arbitrary nibbles and decimal points.
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                step(1'b1, 16'($urandom), 4'($urandom_range(0, 15)));
            end else begin
                idle(1);
            end
        end

        // Asynchronous reset in the middle of a SHOW phase, no clock edge needed.
        while ((cyc % REFRESH_DIV) != BLANK_CYC + 3) idle(1);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_values("rst_async");
        repeat (2) @(posedge CLK);
        #1;
        check_reset_values("rst_async_hold");
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                step(1'b1, 16'($urandom), 4'($urandom_range(0, 15)));
            end else begin
                idle(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
